// File: rtl/cnt_arb_pkg.sv
// rtl/cnt_arb_pkg.sv - shared counter control codes and arbiter state encoding
package cnt_arb_pkg;

    localparam logic [2:0] CTRL_OFF                       = 3'd0;
    localparam logic [2:0] CTRL_RESET_AND_SIGNAL_IF_EQUAL = 3'd3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LOAD = 2'd1,
        ARB_RUN  = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    // Index width for n requesters; never zero so a 1-requester build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_rr_pick.sv
// rtl/cnt_rr_pick.sv - combinational round-robin picker, searches upward from last+1 mod N
module cnt_rr_pick
    import cnt_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] winner
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin : pick
        int idx;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = N; off >= 1; off--) begin
            idx = (int'(last) + off) % N;
            if (req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cnt_arb.sv
// rtl/cnt_arb.sv - round-robin scheduler sharing one programmable counter among N requesters
module cnt_arb
    import cnt_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] period,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   cnt_div,
    output logic [2:0]     cnt_control,
    input  logic [W-1:0]   cnt_dout
);

    localparam int IW = idx_width(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] last_q;
    logic [W-1:0]  period_q;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [W-1:0]  period_sel;

    cnt_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        period_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) begin
                period_sel = period[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            last_q   <= IW'(N - 1);
            period_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && pick_valid) begin
                period_q <= period_sel;
                owner_q  <= pick_idx;
            end
            if (state_q == ARB_DONE) begin
                last_q <= owner_q;
            end
        end
    end

    // Abort outranks completion: a withdrawn requester never sees done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (pick_valid) state_d = ARB_LOAD;
            ARB_LOAD: state_d = ARB_RUN;
            ARB_RUN: begin
                if (!req[owner_q]) begin
                    state_d = ARB_IDLE;
                end else if (cnt_dout >= period_q) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant       = '0;
        done        = '0;
        busy        = (state_q != ARB_IDLE);
        cnt_div     = period_q;
        cnt_control = CTRL_OFF;
        if (state_q != ARB_IDLE) begin
            grant[owner_q] = 1'b1;
        end
        if (state_q == ARB_DONE) begin
            done[owner_q] = 1'b1;
        end
        if (state_q == ARB_RUN) begin
            cnt_control = CTRL_RESET_AND_SIGNAL_IF_EQUAL;
        end
    end

endmodule

// File: tb/tb_cnt_arb.sv
// tb/tb_cnt_arb.sv - directed self-checking bench for cnt_arb with a behavioural counter
module tb_cnt_arb;
    import cnt_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] period = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   cnt_div;
    logic [2:0]     cnt_control;
    logic [W-1:0]   cnt_dout = '0;

    int checks = 0;
    int failures = 0;

    cnt_arb #(.N(N), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .period      (period),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .cnt_div     (cnt_div),
        .cnt_control (cnt_control),
        .cnt_dout    (cnt_dout)
    );

    always #5 clk = ~clk;

    // Counter: counts once per edge in reset-and-signal mode, clears otherwise.
    always @(posedge clk) begin
        if (cnt_control == CTRL_RESET_AND_SIGNAL_IF_EQUAL) cnt_dout <= cnt_dout + 1;
        else cnt_dout <= '0;
    end

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic set_period(input int i, input logic [W-1:0] v);
        period[i*W +: W] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        set_period(0, 7);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cnt_control !== CTRL_OFF) begin failures++; $display("FAIL reset_control got=%0d exp=%0d", cnt_control, CTRL_OFF); end
        checks++; if (cnt_div !== 32'd0) begin failures++; $display("FAIL reset_div got=%0d exp=0", cnt_div); end
        req   = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int done_at = -1;
        int ndone = 0;
        logic [N-1:0] done_val = '0;
        logic busy_after = 1'b1;
        do_reset();
        set_period(0, 5);
        req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", grant); end
                checks++; if (cnt_div !== 32'd5) begin failures++; $display("FAIL single_div got=%0d exp=5", cnt_div); end
            end
            if (done != 0) begin
                ndone++;
                if (done_at < 0) begin done_at = c; done_val = done; end
                req = '0;
            end
            if (c == 9) busy_after = busy;
        end
        checks++; if (done_at != 8) begin failures++; $display("FAIL single_done_cycle got=%0d exp=8", done_at); end
        checks++; if (done_val !== 4'b0001) begin failures++; $display("FAIL single_done_bits got=%b exp=0001", done_val); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy_after); end
    endtask

    task automatic test_contention();
        int gseq[5];
        int ngr = 0, ndn = 0, bad_oh = 0, bad_done = 0, load2 = -1;
        logic [N-1:0] prev = '0;
        do_reset();
        for (int i = 0; i < N; i++) set_period(i, 2);
        for (int i = 0; i < 5; i++) gseq[i] = -1;
        req = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (grant != 0 && !$onehot(grant)) bad_oh++;
            if (grant != 0 && prev == 0) begin
                if (ngr < 5) gseq[ngr] = oh_idx(grant);
                if (ngr == 1) load2 = c;
                ngr++;
            end
            if (done != 0) begin
                ndn++;
                if (done !== grant) bad_done++;
            end
            prev = grant;
        end
        req = '0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (gseq[i] != i % N) begin failures++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, gseq[i], i % N); end
        end
        checks++; if (ngr != 5) begin failures++; $display("FAIL contention_grants got=%0d exp=5", ngr); end
        checks++; if (ndn != 5) begin failures++; $display("FAIL contention_dones got=%0d exp=5", ndn); end
        checks++; if (bad_oh != 0) begin failures++; $display("FAIL contention_onehot got=%0d exp=0", bad_oh); end
        checks++; if (bad_done != 0) begin failures++; $display("FAIL contention_done_owner got=%0d exp=0", bad_done); end
        checks++; if (load2 != 7) begin failures++; $display("FAIL contention_second_load got=%0d exp=7", load2); end
    endtask

    task automatic test_zero_period();
        int done_at = -1;
        logic [N-1:0] done_val = '0;
        do_reset();
        set_period(1, 0);
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL zero_grant got=%b exp=0010", grant); end
                checks++; if (cnt_div !== 32'd0) begin failures++; $display("FAIL zero_div got=%0d exp=0", cnt_div); end
            end
            if (done != 0 && done_at < 0) begin done_at = c; done_val = done; req = '0; end
        end
        checks++; if (done_at != 3) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=3", done_at); end
        checks++; if (done_val !== 4'b0010) begin failures++; $display("FAIL zero_done_bits got=%b exp=0010", done_val); end
    endtask

    task automatic test_abort();
        int seen_done = 0;
        do_reset();
        set_period(2, 100);
        req = 4'b0100;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (done != 0) seen_done++;
            if (c == 11) begin
                checks++; if (cnt_control !== CTRL_RESET_AND_SIGNAL_IF_EQUAL) begin failures++; $display("FAIL abort_run_control got=%0d exp=%0d", cnt_control, CTRL_RESET_AND_SIGNAL_IF_EQUAL); end
                checks++; if (cnt_dout !== 32'd9) begin failures++; $display("FAIL abort_run_dout got=%0d exp=9", cnt_dout); end
                req = '0;
            end
            if (c == 12) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
                checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL abort_grant got=%b exp=0000", grant); end
                checks++; if (cnt_control !== CTRL_OFF) begin failures++; $display("FAIL abort_control got=%0d exp=%0d", cnt_control, CTRL_OFF); end
            end
        end
        checks++; if (seen_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        set_period(2, 20);
        set_period(0, 3);
        req = 4'b0100;
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
        reset = 1'b1;
        req   = 4'b0111;
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL midrst_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (cnt_div !== 32'd0) begin failures++; $display("FAIL midrst_div got=%0d exp=0", cnt_div); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL midrst_done got=%b exp=0000", done); end
        checks++; if (cnt_control !== CTRL_OFF) begin failures++; $display("FAIL midrst_control got=%0d exp=%0d", cnt_control, CTRL_OFF); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL midrst_first_winner got=%b exp=0001", grant); end
        req = '0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_period_change();
        int done_at = -1;
        do_reset();
        set_period(0, 5);
        req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 4) set_period(0, 50);
            if (c == 6) begin
                checks++; if (cnt_div !== 32'd5) begin failures++; $display("FAIL pchg_div got=%0d exp=5", cnt_div); end
            end
            if (done != 0 && done_at < 0) begin done_at = c; req = '0; end
        end
        checks++; if (done_at != 8) begin failures++; $display("FAIL pchg_done_cycle got=%0d exp=8", done_at); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_period();
        test_abort();
        test_reset_mid_run();
        test_period_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_arb.md
# cnt_arb

Round-robin scheduler that shares one programmable counter among N requesters. Each requester asks for a timed interval of a given length. The arbiter grants one requester at a time, programs the counter's `div`/`control` inputs, watches the counter's `dout`, and pulses `done` back to the winner when its interval expires. It sits between the requesting blocks and a single counter instance; it owns that counter's control inputs outright.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `W`, 32: period and counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N  level request per requester.
- `period`  in  N*W  per-requester interval; slice i is `period[i*W +: W]`.
- `grant`  out  N  one-hot, the current owner; all zero when idle.
- `done`  out  N  one-cycle pulse to the owner on completion.
- `busy`  out  1  high in every state except IDLE.
- `cnt_div`  out  W  drives counter `div`.
- `cnt_control`  out  3  drives counter `control`; codes come from `cnt.vh`.
- `cnt_dout`  in  W  counter `dout`.

## Operation
The controller is a four-state FSM.
- **IDLE**
  - `cnt_control` = `CTRL_OFF`.
  - If `req` is nonzero, the round-robin picker selects index k, searching upward from `last+1` modulo N.
  - On the next edge it latches `period_q` = slice k and `owner` = k, then moves to LOAD.
- **LOAD**
  - `cnt_control` = `CTRL_OFF`, `cnt_div` = `period_q`.
  - This single cycle lets the counter capture `div` and clear `data`. Next state is RUN.
- **RUN**
  - `cnt_control` = `CTRL_RESET_AND_SIGNAL_IF_EQUAL`, `cnt_div` = `period_q`.
  - If `cnt_dout >= period_q` (unsigned), move to DONE.
  - If `req[owner]` is low, abort to IDLE with no `done` pulse. Abort has priority over completion in the same cycle.
- **DONE**
  - `done[owner]` = 1 for exactly this cycle, `cnt_control` = `CTRL_OFF`.
  - `last` = `owner`, then move to IDLE.
- `grant[owner]` is high in LOAD, RUN and DONE.
- `cnt_div` holds `period_q` from LOAD until the next grant.
- `period` is sampled only at the IDLE→LOAD edge; later changes are ignored until the next grant.
- Requests arriving while busy wait. `req` is level-sensitive: a requester that keeps `req` high after `done` re-enters arbitration at lowest priority.
- `period` = 0 is legal: RUN sees `cnt_dout` = 0 on its first cycle and completes.
- The `>=` comparison is deliberate. Completion must not be missed if `dout` steps past `period_q` within a cycle.

## Timing
- Reset values:
  - state IDLE, `grant` = 0, `done` = 0, `busy` = 0.
  - `cnt_control` = `CTRL_OFF`, `cnt_div` = 0, `period_q` = 0.
  - `last` = N-1, so requester 0 wins first.
- Reset mid-operation: on the next edge all outputs and state return to reset values with no `done` pulse, and the counter is forced OFF.
- With a counter advancing once per rising edge, take `req` sampled high in IDLE at edge t:
  - LOAD is the cycle after edge t.
  - RUN lasts P+1 cycles.
  - `done` is high for one cycle, P+3 cycles after edge t.
  - The next grant can start LOAD 2 cycles after the DONE cycle (DONE→IDLE, then IDLE→LOAD).
- No combinational path from `req` or `period` to any output. All outputs are registered or decoded from registered state.

## Structure
- `cnt.vh` (shared) holds:
  - the existing `CTRL_*` counter codes;
  - new `ARB_IDLE`, `ARB_LOAD`, `ARB_RUN`, `ARB_DONE` 2-bit state encodings.
- Sub-module `cnt_rr_pick`: combinational round-robin picker, parameterized by N.
  - Inputs: `req[N-1:0]`, `last` index.
  - Outputs: `valid`, winner index.
  - Reused by future arbiters in the codebase.
- `cnt_arb` holds the FSM, the `period_q`/`owner`/`last` registers and the comparator.

## Test plan
The bench uses a behavioural counter model that increments once per rising edge in the reset-and-signal mode and clears in `CTRL_OFF`.
1. **Single request:** reset, then `req` = 0001 with period0 = 5 → `grant` = 0001 from LOAD; `done[0]` pulses once, 8 cycles after the sampling edge; `busy` drops the cycle after.
2. **Contention:** `req` = 1111 held, all periods = 2 → grants in order 0, 1, 2, 3, 0; exactly one `done` per grant; `grant` stays one-hot.
3. **Zero period:** period1 = 0, `req` = 0010 → `done[1]` 3 cycles after sampling; `cnt_div` = 0.
4. **Abort:** period2 = 100, `req[2]` dropped on the 10th RUN cycle → return to IDLE with no `done`; `cnt_control` = `CTRL_OFF` the next cycle.
5. **Reset mid-RUN:** `reset` during RUN → next cycle `grant` = 0, `busy` = 0, `cnt_div` = 0; requester 0 wins first afterwards.
6. **Period change during RUN:** period0 changed from 5 to 50 mid-interval → completion still at 5.
